// File: rtl/muldiv_unit_if.sv
// Core-side bundle for the multiply/divide unit: request, operands, mthi/mtlo
// strobes going in; handshake flags and the HI/LO registers coming back.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ena;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output ena, start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  ena, start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative mult/multu/div/divu with HI/LO registers: one bit per cycle on
// operand magnitudes, signs restored in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic               is_div_reg, is_div_next;
  logic               neg_lo_reg, neg_lo_next;
  logic               neg_hi_reg, neg_hi_next;
  logic               dz_reg, dz_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // already its correct unsigned magnitude.
  logic             is_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_signed = ~bus.op[0];
  assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
    assign addend[gi] = opnd_reg[gi] & acc_reg[0];
  end

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

  // Restoring step: the partial remainder stays below the divisor, so the
  // W-bit difference is exact whenever the subtraction is taken.
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_diff;

  assign div_shift = {rem_reg, acc_reg[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rmd_fix;

  assign prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rmd_fix  = neg_hi_reg ? -rem_reg : rem_reg;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    acc_next      = acc_reg;
    rem_next      = rem_reg;
    opnd_next     = opnd_reg;
    is_div_next   = is_div_reg;
    neg_lo_next   = neg_lo_reg;
    neg_hi_next   = neg_hi_reg;
    dz_next       = dz_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    div_zero_next = 1'b0;
    hi_next       = hi_reg;
    lo_next       = lo_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (bus.hi_we) hi_next = bus.wdata;
        if (bus.lo_we) lo_next = bus.wdata;
        if (bus.start) begin
          busy_next   = 1'b1;
          count_next  = CW'(WIDTH);
          is_div_next = bus.op[1];
          neg_lo_next = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_hi_next = is_signed & bus.a[WIDTH-1];
          dz_next     = 1'b0;
          rem_next    = '0;
          if (bus.op[1] && (bus.b == '0)) begin
            // Keep the raw dividend so FIX can hand it back in HI.
            dz_next    = 1'b1;
            acc_next   = {{WIDTH{1'b0}}, bus.a};
            state_next = S_FIX;
          end else if (bus.op[1]) begin
            acc_next   = {{WIDTH{1'b0}}, a_mag};
            opnd_next  = b_mag;
            state_next = S_RUN;
          end else begin
            acc_next   = {{WIDTH{1'b0}}, b_mag};
            opnd_next  = a_mag;
            state_next = S_RUN;
          end
        end
      end

      S_RUN: begin
        count_next = count_reg - CW'(1);
        if (is_div_reg) begin
          acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], div_ok};
          rem_next = div_ok ? div_diff : div_shift[WIDTH-1:0];
        end else begin
          acc_next = mul_step;
        end
        if (count_reg == CW'(1)) state_next = S_FIX;
      end

      S_FIX: begin
        state_next    = S_IDLE;
        busy_next     = 1'b0;
        done_next     = 1'b1;
        div_zero_next = dz_reg;
        if (dz_reg) begin
          hi_next = acc_reg[WIDTH-1:0];
          lo_next = '1;
        end else if (is_div_reg) begin
          hi_next = rmd_fix;
          lo_next = quo_fix;
        end else begin
          hi_next = prod_fix[2*WIDTH-1:WIDTH];
          lo_next = prod_fix[WIDTH-1:0];
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      neg_lo_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      dz_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else if (bus.ena) begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      acc_reg      <= acc_next;
      rem_reg      <= rem_next;
      opnd_reg     <= opnd_next;
      is_div_reg   <= is_div_next;
      neg_lo_reg   <= neg_lo_next;
      neg_hi_reg   <= neg_hi_next;
      dz_reg       <= dz_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      div_zero_reg <= div_zero_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: expected HI/LO/div_zero are queued at
// issue time from a plain-arithmetic model and popped by a done monitor.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus_if ();
  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic [64:0] exp_q[$];
  logic        held_done = 1'b0;
  logic [64:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Result as {div_zero, hi, lo}, from 64-bit integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, p, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00: begin
        p = sa * sb;
        return {1'b0, p[63:32], p[31:0]};
      end
      2'b01: begin
        pu = ua * ub;
        return {1'b0, pu[63:32], pu[31:0]};
      end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        p = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], p[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst && bus_if.done && !held_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual hi=%h lo=%h required no done", bus_if.hi, bus_if.lo);
        end else begin
          mon_exp = exp_q.pop_front();
          $display("done: hi=%h lo=%h div_zero=%0b", bus_if.hi, bus_if.lo, bus_if.div_zero);
          check("hi", 64'(bus_if.hi), 64'(mon_exp[63:32]));
          check("lo", 64'(bus_if.lo), 64'(mon_exp[31:0]));
          check("div_zero", 64'(bus_if.div_zero), 64'(mon_exp[64]));
        end
      end
      held_done = bus_if.done && !bus_if.ena;
    end
  end

  // mode: 0 plain, 1 ena low 5 cycles, 2 stray start + hi_we in RUN,
  //       3 reset mid-RUN, 4 mthi/mtlo together with start
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int mode);
    int         n, busy_n, exp_lat, dc0;
    logic [31:0] hi_before;
    exp_lat = (op[1] && b == 32'd0) ? 1 : W + 1;
    if (mode == 1) exp_lat += 5;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.start = 1'b1;
    if (mode == 4) begin
      bus_if.hi_we = 1'b1;
      bus_if.lo_we = 1'b1;
      bus_if.wdata = 32'hC3C3_3C3C;
    end
    if (mode != 3) exp_q.push_back(ref_model(op, a, b));
    $display("issue: op=%0d a=%h b=%h mode=%0d", op, a, b, mode);
    dc0 = done_cnt;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.hi_we = 1'b0;
    bus_if.lo_we = 1'b0;
    if (mode == 4) begin
      check("mthi_with_start", 64'(bus_if.hi), 64'h0000_0000_C3C3_3C3C);
      check("mtlo_with_start", 64'(bus_if.lo), 64'h0000_0000_C3C3_3C3C);
    end
    hi_before = bus_if.hi;
    busy_n = 0;
    n = 0;
    while (n < 200) begin
      if (bus_if.busy) busy_n++;
      if (mode == 1 && n == 10) bus_if.ena = 1'b0;
      if (mode == 1 && n == 15) bus_if.ena = 1'b1;
      if (mode == 2 && n == 5) begin
        bus_if.start = 1'b1;
        bus_if.op    = 2'($urandom_range(0, 3));
        bus_if.a     = $urandom;
        bus_if.b     = $urandom;
      end
      if (mode == 2 && n == 6) bus_if.start = 1'b0;
      if (mode == 2 && n == 7) begin
        bus_if.hi_we = 1'b1;
        bus_if.wdata = ~hi_before;
      end
      if (mode == 2 && n == 8) begin
        bus_if.hi_we = 1'b0;
        check("hi_we_in_run", 64'(bus_if.hi), 64'(hi_before));
      end
      if (mode == 3 && n == 10) rst = 1'b0;
      if (mode == 3 && n == 11) begin
        rst = 1'b1;
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_hi", 64'(bus_if.hi), 64'd0);
        check("rst_lo", 64'(bus_if.lo), 64'd0);
      end
      @(posedge clk);
      #1;
      n++;
      if (bus_if.done) break;
      if (mode == 3 && n == 60) break;
    end
    if (mode != 3) begin
      check("latency", 64'(n), 64'(exp_lat));
      check("busy_cycles", 64'(busy_n), 64'(exp_lat));
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("done_count", 64'(done_cnt - dc0), (mode == 3) ? 64'd0 : 64'd1);
    check("idle_after", 64'(bus_if.busy), 64'd0);
  endtask

  initial begin : stim
    logic [1:0]  op;
    logic [31:0] a, b;
    bus_if.ena   = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.hi_we = 1'b0;
    bus_if.lo_we = 1'b0;
    bus_if.wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_done", 64'(bus_if.done), 64'd0);
    check("reset_div_zero", 64'(bus_if.div_zero), 64'd0);
    check("reset_hi", 64'(bus_if.hi), 64'd0);
    check("reset_lo", 64'(bus_if.lo), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    bus_if.hi_we = 1'b1;
    bus_if.wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    bus_if.hi_we = 1'b0;
    bus_if.lo_we = 1'b1;
    bus_if.wdata = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    bus_if.lo_we = 1'b0;
    $display("mthi/mtlo: hi=%h lo=%h", bus_if.hi, bus_if.lo);
    check("mthi", 64'(bus_if.hi), 64'h0000_0000_A5A5_A5A5);
    check("mtlo", 64'(bus_if.lo), 64'h0000_0000_5A5A_5A5A);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd100, 32'd7, 0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b01, 32'd3, 32'd4, 1);
    run_op(2'b11, $urandom, $urandom | 32'd1, 2);
    run_op(2'b00, $urandom, $urandom, 4);
    run_op(2'b01, $urandom, $urandom, 3);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 0);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers. It extends the single-cycle MIPS core toward the 54-instruction set with mult, multu, div, divu, mthi, mtlo, mfhi and mflo. The core starts an operation and stalls its PC on `busy`; results land in internal HI/LO registers, which are read combinationally for mfhi/mflo. Operand width is parametrised, and the unit adds a multi-cycle start/busy/done handshake that the single-cycle core does not have.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. Must be ≥ 4 and even.

Ports:
- `clk` input 1: sole clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `ena` input 1: global enable. When low, all state is frozen.
- `start` input 1: request. Accepted only in IDLE with `ena` high.
- `op` input 2: operation select. 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `a` input WIDTH: multiplicand / dividend (rs).
- `b` input WIDTH: multiplier / divisor (rt).
- `hi_we` input 1: mthi strobe.
- `lo_we` input 1: mtlo strobe.
- `wdata` input WIDTH: mthi/mtlo data.
- `busy` output 1: operation in flight. The core holds its PC while this is high.
- `done` output 1: one-cycle pulse; HI/LO are updated and valid.
- `div_zero` output 1: pulses together with `done` on a divide whose divisor is 0.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation

- States:
  - IDLE
  - RUN: iterate, one bit per cycle, `WIDTH` cycles.
  - FIX: sign correction and HI/LO write.
- IDLE to RUN on `start`:
  - Latch `op`.
  - Signed ops convert operands to magnitudes and record the result signs:
    - product sign = a[MSB]^b[MSB]
    - quotient sign = a[MSB]^b[MSB]
    - remainder sign = a[MSB]
  - Load the bit counter with `WIDTH`.
- RUN, multiply: shift-add on a 2·WIDTH accumulator.
- RUN, divide: restoring divide on a WIDTH+1-bit partial remainder.
- RUN to FIX when the counter reaches 0.
- FIX to IDLE:
  - Negate results per the recorded signs.
  - Multiply: HI = upper half, LO = lower half of the 2·WIDTH product.
  - Divide: LO = quotient, HI = remainder.
  - Assert `done`.
- Divide by zero (b == 0 on an accepted div/divu): skip RUN and go IDLE to FIX directly. FIX writes HI = a, LO = all ones, and pulses `done` and `div_zero`.
- Signed divide overflow (most-negative / −1): quotient wraps to most-negative, remainder 0. No flag.
- Arithmetic is modulo 2^WIDTH per half. No overflow exceptions.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE with `ena` high; they write `wdata` on the edge.
  - Ignored while busy.
  - If asserted in the same cycle as an accepted `start`: the write takes effect, and the operation result overwrites it on completion.
- `start` while busy: ignored. It is not queued.
- `ena` low: state, counter, HI/LO and outputs are all held. A `done` that is high stays high until the next enabled edge.

## Timing

- Reset (`rst` = 0 at an edge):
  - state = IDLE
  - `busy` = 0, `done` = 0, `div_zero` = 0
  - `hi` = 0, `lo` = 0
  - Reset mid-operation aborts with no HI/LO write.
- `busy` is a registered output, high from the edge that accepts `start` until the FIX edge.
- Latency counts enabled edges after the accepting edge:
  - Normal operation: `WIDTH`+1. The first edge is FIX-bound after `WIDTH` RUN edges; `done` is high in the cycle after edge `WIDTH`+1.
  - Divide by zero: 1.
- `done`/`div_zero` are single-cycle registered pulses. They coincide with `busy` falling and HI/LO holding the new values.
- A new `start` is accepted in the same cycle `done` is high, since the unit is already in IDLE. Back-to-back throughput is `WIDTH`+2 cycles.
- `hi`/`lo` change only on the FIX edge, an mthi/mtlo edge, or reset.

## Test plan

1. multu, a = b = 0xFFFFFFFF (`WIDTH` = 32):
   - `busy` high 33 cycles; `done` in cycle 34.
   - HI = 0xFFFFFFFE, LO = 0x00000001.
2. mult, a = 0xFFFFFFFD (−3), b = 5: HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
3. Division, signed and unsigned:
   - div, a = 0xFFFFFFF9 (−7), b = 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
   - divu, a = 100, b = 7: LO = 14, HI = 2.
4. Divide edge cases:
   - divu, a = 0x1234, b = 0: `done` and `div_zero` on the next edge; HI = 0x1234, LO = 0xFFFFFFFF.
   - div, a = 0x80000000, b = 0xFFFFFFFF: LO = 0x80000000, HI = 0, `div_zero` = 0.
5. Write ports and stray starts:
   - mthi 0xA5A5A5A5 and mtlo 0x5A5A5A5A in IDLE: read back exactly.
   - `hi_we` during RUN is ignored.
   - A second `start` at cycle 5 of RUN is ignored; only one `done` results.
6. Enable and reset:
   - multu 3×4 with `ena` low for 5 cycles mid-RUN: `done` delayed by exactly 5 cycles; LO = 12.
   - `rst` = 0 at RUN cycle 10: next cycle `busy` = 0, HI = LO = 0, and no `done` ever appears.
